// File: rtl/execute_cycle_pkg.sv
// Shared core package: ALU operation encodings, forwarding selects and the EX/MEM
// register layout. The control unit and the hazard unit import it as well.
package execute_cycle_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  // 2'b11 is unused by the hazard unit and falls back to the register-file value.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  result_src;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       write_data;
    logic [XLEN-1:0]       pc_plus4;
  } ex_mem_t;

  function automatic logic [XLEN-1:0] fwd_mux(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] reg_val,
    input logic [XLEN-1:0] wb_val,
    input logic [XLEN-1:0] mem_val
  );
    logic [XLEN-1:0] val;
    case (sel)
      FWD_WB:  val = wb_val;
      FWD_MEM: val = mem_val;
      default: val = reg_val;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/execute_cycle_if.sv
// Execute-stage bus: ID/EX fields, forwarding inputs and the EX/MEM register outputs.
interface execute_cycle_if;
  import execute_cycle_pkg::*;

  logic                  RegWriteE;
  logic                  ALUSrcE;
  logic                  MemWriteE;
  logic                  ResultSrcE;
  logic                  BranchE;
  logic [2:0]            ALUControlE;
  logic [XLEN-1:0]       RD1_E;
  logic [XLEN-1:0]       RD2_E;
  logic [XLEN-1:0]       Imm_Ext_E;
  logic [REG_ADDR_W-1:0] RD_E;
  logic [XLEN-1:0]       PCE;
  logic [XLEN-1:0]       PCPlus4E;
  logic [XLEN-1:0]       ResultW;
  logic [1:0]            ForwardA_E;
  logic [1:0]            ForwardB_E;

  logic                  PCSrcE;
  logic [XLEN-1:0]       PCTargetE;
  logic                  RegWriteM;
  logic                  MemWriteM;
  logic                  ResultSrcM;
  logic [REG_ADDR_W-1:0] RD_M;
  logic [XLEN-1:0]       ALUResultM;
  logic [XLEN-1:0]       WriteDataM;
  logic [XLEN-1:0]       PCPlus4M;

  modport master (
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ResultW,
           ForwardA_E, ForwardB_E,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ResultW,
           ForwardA_E, ForwardB_E,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );

endinterface

// File: rtl/execute_cycle_alu.sv
// Integer ALU: add/sub wrap modulo 2^32, signed set-less-than, unknown codes give 0.
module alu
  import execute_cycle_pkg::*;
(
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  always_comb begin
    // NOTE: default assignment first so every path drives Result and no latch is inferred.
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
module execute_cycle
  import execute_cycle_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  execute_cycle_if.slave  bus
);

  ex_mem_t         ex_mem_q;
  ex_mem_t         ex_mem_d;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            zero;

  // Forwarding from MEM uses the registered result, so there is no loop through the ALU.
  assign src_a = fwd_mux(bus.ForwardA_E, bus.RD1_E, bus.ResultW, ex_mem_q.alu_result);
  assign fwd_b = fwd_mux(bus.ForwardB_E, bus.RD2_E, bus.ResultW, ex_mem_q.alu_result);
  assign src_b = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;

  alu u_alu (
    .A          (src_a),
    .B          (src_b),
    .ALUControl (bus.ALUControlE),
    .Result     (alu_result),
    .Zero       (zero)
  );

  assign bus.PCSrcE    = bus.BranchE & zero;
  assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

  // Stores write the forwarded register value, never the address immediate.
  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.reg_write  = bus.RegWriteE;
    ex_mem_d.mem_write  = bus.MemWriteE;
    ex_mem_d.result_src = bus.ResultSrcE;
    ex_mem_d.rd         = bus.RD_E;
    ex_mem_d.alu_result = alu_result;
    ex_mem_d.write_data = fwd_b;
    ex_mem_d.pc_plus4   = bus.PCPlus4E;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!rst) ex_mem_q <= '0;
    else      ex_mem_q <= ex_mem_d;
  end

  assign bus.RegWriteM  = ex_mem_q.reg_write;
  assign bus.MemWriteM  = ex_mem_q.mem_write;
  assign bus.ResultSrcM = ex_mem_q.result_src;
  assign bus.RD_M       = ex_mem_q.rd;
  assign bus.ALUResultM = ex_mem_q.alu_result;
  assign bus.WriteDataM = ex_mem_q.write_data;
  assign bus.PCPlus4M   = ex_mem_q.pc_plus4;

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 SHALL have clk, input, 1 -- clock; all state updates on the rising edge.
REQ-002 SHALL have rst, input, 1 -- reset, synchronous, active-low.
REQ-003 SHALL have RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, input, 1 each -- control bits from the ID/EX register.
REQ-004 SHALL have ALUControlE, input, 3 -- ALU operation select.
REQ-005 SHALL have RD1_E, RD2_E, Imm_Ext_E, input, 32 each -- register operands and extended immediate.
REQ-006 SHALL have RD_E, input, 5 -- destination register index.
REQ-007 SHALL have PCE, PCPlus4E, input, 32 each -- instruction PC and PC+4.
REQ-008 SHALL have ResultW, input, 32 -- writeback value for forwarding.
REQ-009 SHALL have ForwardA_E, ForwardB_E, input, 2 each -- operand source select from the hazard unit.
REQ-010 SHALL have PCSrcE, output, 1 -- branch taken (combinational).
REQ-011 SHALL have PCTargetE, output, 32 -- branch target (combinational).
REQ-012 SHALL have RegWriteM, MemWriteM, ResultSrcM, output, 1 each -- registered control bits.
REQ-013 SHALL have RD_M, output, 5, and ALUResultM, WriteDataM, PCPlus4M, output, 32 each -- EX/MEM register outputs.

Function
REQ-014 Operand A SHALL be RD1_E when ForwardA_E=00, ResultW when 01, ALUResultM when 10, and RD1_E when 11.
REQ-015 Forwarded B SHALL use the same selection over RD2_E/ResultW/ALUResultM with ForwardB_E.
REQ-016 Operand B SHALL be Imm_Ext_E when ALUSrcE=1, otherwise forwarded B.
REQ-017 ALUControlE encodings SHALL be: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed, result 1 or 0); other codes produce 0.
REQ-018 Add and sub SHALL wrap modulo 2^32, with no overflow or carry output.
REQ-019 ZeroE SHALL be 1 exactly when the ALU result equals 0.
REQ-020 PCSrcE SHALL equal BranchE AND ZeroE.
REQ-021 PCTargetE SHALL equal PCE + Imm_Ext_E modulo 2^32.
REQ-022 PCSrcE and PCTargetE SHALL be purely combinational from the current E inputs and ALUResultM, with no reset value.
REQ-023 On each rising edge with rst=1, the EX/MEM register SHALL load:
- RegWriteE, MemWriteE, ResultSrcE
- RD_E, PCPlus4E
- the ALU result into ALUResultM
- forwarded B (not the immediate) into WriteDataM
REQ-024 Latency from the E inputs to the M outputs SHALL be exactly one clock, with no stall or bubble insertion inside this block.
REQ-025 Selecting ALUResultM for forwarding SHALL use the value registered on the previous edge, giving no combinational loop.
REQ-026 BranchE and the branch result SHALL NOT be propagated to the M outputs.

Reset
REQ-027 When rst=0 at a rising edge, all M outputs (RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M) SHALL become 0.
REQ-028 Reset asserted mid-stream SHALL discard the instruction presented that cycle.
REQ-029 The first edge after rst returns to 1 SHALL capture the E inputs normally.

Structure
REQ-030 The ALUControl encodings and the forwarding-select constants (00/01/10) SHALL live in the shared core package, also used by the control unit and hazard unit.
REQ-031 The ALU SHALL be a separate sub-module named alu (inputs A, B, ALUControl; outputs Result, Zero), instantiated once.

Verification
REQ-032 Reset: rst=0 for one edge with all inputs nonzero -> every M output reads 0 after the edge.
REQ-033 Add wrap: RD1_E=FFFFFFFF, RD2_E=00000002, ALUControlE=000, ALUSrcE=0, RD_E=5 -> next cycle ALUResultM=00000001, RD_M=5.
REQ-034 beq taken and not taken:
- RD1_E=RD2_E=7, ALUControlE=001, BranchE=1, PCE=100, Imm_Ext_E=FFFFFFF8 -> PCSrcE=1, PCTargetE=F8 in the same cycle.
- RD2_E=8 -> PCSrcE=0.
REQ-035 Forwarding:
- Cycle n: ALUResultM=0000000A; set ForwardA_E=10, ForwardB_E=01, ResultW=3, add -> next ALUResultM=0000000D.
- ForwardA_E=11 -> RD1_E is used.
REQ-036 Store path: ALUSrcE=1, Imm_Ext_E=4, RD1_E=1000, RD2_E=DEADBEEF, MemWriteE=1 -> ALUResultM=1004, WriteDataM=DEADBEEF, MemWriteM=1.
REQ-037 slt signed: RD1_E=FFFFFFFF, RD2_E=1, ALUControlE=101 -> ALUResultM=1; ALUControlE=111 -> ALUResultM=0.
